// File: rtl/moesi_snoop_ctrl.sv
// moesi_snoop_ctrl: services interconnect snoops against the private cache's MOESI
// state/tag store via RAM port 2. Each request reads the set, compares the tag, applies
// the MOESI snoop transition, writes the new state back if it changed, and returns a
// hit/dirty/supply/shared response. A same-set write on core port 1 during the lookup
// silently drops or stales the port-2 access, so the lookup is retried.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   snp_valid/snp_ready/snp_addr/snp_type   snoop request (00 Rd, 01 RdX, 10 Upgr, 11 = Rd)
//   resp_valid/resp_ready/resp_*  snoop response, held until consumed
//   core_w_en1, core_rw_addr1     monitor of the core RAM port
//   rw_addr2, w_en2, w_state_tag2, r_state_tag2   RAM port 2 (read data one cycle late)
//   snp_hit_cnt, snp_retry_cnt    statistics counters
//
// Optional feature: define SNOOP_STATS_EN to build the saturating counters; otherwise
// both counter outputs are tied to 0.
`timescale 1ns/1ps
module moesi_snoop_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned SET_WIDTH    = 4,
  parameter int unsigned STATE_WIDTH  = 3,
  parameter int unsigned TAG_WIDTH    = 22
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             snp_valid,
  output logic                             snp_ready,
  input  logic [ADDR_WIDTH-1:0]            snp_addr,
  input  logic [1:0]                       snp_type,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic                             resp_hit,
  output logic                             resp_dirty,
  output logic                             resp_supply,
  output logic                             resp_shared,
  input  logic                             core_w_en1,
  input  logic [SET_WIDTH-1:0]             core_rw_addr1,
  output logic [SET_WIDTH-1:0]             rw_addr2,
  output logic                             w_en2,
  output logic [STATE_WIDTH+TAG_WIDTH-1:0] w_state_tag2,
  input  logic [STATE_WIDTH+TAG_WIDTH-1:0] r_state_tag2,
  output logic [15:0]                      snp_hit_cnt,
  output logic [15:0]                      snp_retry_cnt
);

  localparam logic [STATE_WIDTH-1:0] MoesiM = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] MoesiO = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] MoesiE = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] MoesiS = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] MoesiI = STATE_WIDTH'(4);

  typedef enum logic [2:0] {StIdle, StLookup, StCompare, StWrite, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   ready_q;
  logic [SET_WIDTH-1:0]   set_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [1:0]             type_q;
  logic [STATE_WIDTH-1:0] new_state_q;
  logic                   hit_q, dirty_q, supply_q, shared_q;

  logic [STATE_WIDTH-1:0] rd_state, old_state, new_state;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic                   hit, supply, accept, collision, in_access;

  assign rd_state = r_state_tag2[STATE_WIDTH+TAG_WIDTH-1 -: STATE_WIDTH];
  assign rd_tag   = r_state_tag2[TAG_WIDTH-1:0];
  assign hit      = (rd_state != MoesiI) && (rd_tag == tag_q);
  assign old_state = hit ? rd_state : MoesiI;

  // MOESI snoop transition; supply only possible from M/O/E, which imply a hit.
  always_comb begin
    new_state = old_state;
    supply    = 1'b0;
    case (type_q)
      2'b01: begin
        new_state = MoesiI;
        supply    = (old_state == MoesiM) || (old_state == MoesiO) || (old_state == MoesiE);
      end
      2'b10: new_state = MoesiI;
      default: begin
        case (old_state)
          MoesiM:  begin new_state = MoesiO; supply = 1'b1; end
          MoesiO:  supply = 1'b1;
          MoesiE:  begin new_state = MoesiS; supply = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  assign accept    = (state_q == StIdle) && ready_q && snp_valid;
  assign in_access = (state_q == StLookup) || (state_q == StCompare) || (state_q == StWrite);
  assign collision = in_access && core_w_en1 && (core_rw_addr1 == set_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StLookup;
      StLookup:  state_d = StCompare;
      StCompare: state_d = (new_state != old_state) ? StWrite : StResp;
      StWrite:   state_d = StResp;
      StResp:    if (resp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (collision) state_d = StLookup;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      set_q       <= '0;
      tag_q       <= '0;
      type_q      <= '0;
      new_state_q <= '0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      supply_q    <= 1'b0;
      shared_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (accept) begin
        set_q  <= snp_addr[OFFSET_WIDTH +: SET_WIDTH];
        tag_q  <= snp_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
        type_q <= snp_type;
      end
      if ((state_q == StCompare) && !collision) begin
        new_state_q <= new_state;
        hit_q       <= hit;
        dirty_q     <= hit && ((old_state == MoesiM) || (old_state == MoesiO));
        supply_q    <= supply;
        shared_q    <= (new_state != MoesiI);
      end
    end
  end

  assign snp_ready    = (state_q == StIdle) && ready_q;
  assign resp_valid   = (state_q == StResp);
  assign resp_hit     = resp_valid && hit_q;
  assign resp_dirty   = resp_valid && dirty_q;
  assign resp_supply  = resp_valid && supply_q;
  assign resp_shared  = resp_valid && shared_q;
  assign rw_addr2     = (state_q == StIdle) ? '0 : set_q;
  assign w_en2        = (state_q == StWrite);
  // Only a changed, hit line is ever written, so the stored tag equals the snooped tag.
  assign w_state_tag2 = w_en2 ? {new_state_q, tag_q} : '0;

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_cnt_q, retry_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      retry_cnt_q <= '0;
    end else begin
      if (resp_valid && resp_ready && hit_q && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (collision && (retry_cnt_q != 16'hFFFF)) begin
        retry_cnt_q <= retry_cnt_q + 16'd1;
      end
    end
  end

  assign snp_hit_cnt   = hit_cnt_q;
  assign snp_retry_cnt = retry_cnt_q;
`else
  assign snp_hit_cnt   = '0;
  assign snp_retry_cnt = '0;
`endif

endmodule
